// File: rtl/accum_channel_sched_pkg.sv
// Shared accelerator package for the channel-sum scheduler.
// Purpose : holds the FSM state encoding and the default data/config widths
//           used by accum_channel_sched and its accumulator.
// Contents: DW_DEFAULT, CW_DEFAULT, state_t.
package accum_channel_sched_pkg;

    localparam int DW_DEFAULT = 16;
    localparam int CW_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        OUT   = 2'd2
    } state_t;

endpackage

// File: rtl/multichannel_add.sv
// Enable/clear accumulator.
// Purpose : adds din into a running sum on every enabled clock edge; the sum
//           wraps modulo 2^DW with no saturation.
// Ports   : clk  - clock
//           rst  - clear, sampled on the rising edge; takes priority over en
//           en   - add din this edge
//           din  - value to add
//           sum  - current accumulator contents
module multichannel_add #(
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] sum
);

    logic [DW-1:0] sum_q;

    // The owner ORs its async reset into rst, so the register holds zero for
    // as long as reset is held across a clock edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q <= '0;
        end else if (en) begin
            sum_q <= sum_q + din;
        end
    end

    assign sum = sum_q;

endmodule

// File: rtl/accum_channel_sched.sv
// Channel-sum scheduler.
// Purpose : for each job, sums cfg_num_ch input beats into one output and
//           repeats this cfg_num_out times, with valid/ready on both sides.
// Ports   : clk, rst (async, active-high)
//           start, cfg_num_ch, cfg_num_out   - job launch and configuration
//           in_valid, in_data, in_ready      - per-channel partial values
//           out_valid, out_data, out_ready   - channel sums
//           busy, done                       - job status
module accum_channel_sched
    import accum_channel_sched_pkg::*;
#(
    parameter int DW = DW_DEFAULT,
    parameter int CW = CW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [CW-1:0] cfg_num_ch,
    input  logic [CW-1:0] cfg_num_out,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    input  logic          out_ready,
    output logic          busy,
    output logic          done
);

    localparam logic [CW-1:0] ONE = CW'(1);

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] num_ch;
    logic [CW-1:0] num_out;
    logic [CW-1:0] ch_cnt;
    logic [CW-1:0] out_cnt;
    logic [DW-1:0] acc_sum;
    logic          start_acc;
    logic          beat_acc;
    logic          out_hs;
    logic          last_ch;
    logic          last_out;
    logic          acc_clr;
    logic          done_q;

    assign start_acc = (state == IDLE) && start;
    assign beat_acc  = in_valid && in_ready;
    assign out_hs    = out_valid && out_ready;
    assign last_ch   = (ch_cnt == num_ch - ONE);
    assign last_out  = (out_cnt == num_out - ONE);

    // Clear on job launch and after each delivered sum, so the beat that
    // follows an output handshake is added to zero.
    assign acc_clr = rst || start_acc || out_hs;

    multichannel_add #(
        .DW(DW)
    ) u_acc (
        .clk (clk),
        .rst (acc_clr),
        .en  (beat_acc),
        .din (in_data),
        .sum (acc_sum)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = ACCUM;
                end
            end
            ACCUM: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid && last_ch) begin
                    state_next = OUT;
                end
            end
            OUT: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                if (out_ready) begin
                    state_next = last_out ? IDLE : ACCUM;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Configuration is latched only at launch; a zero count means one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            num_ch  <= '0;
            num_out <= '0;
            ch_cnt  <= '0;
            out_cnt <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= out_hs && last_out;
            if (start_acc) begin
                num_ch  <= (cfg_num_ch  == '0) ? ONE : cfg_num_ch;
                num_out <= (cfg_num_out == '0) ? ONE : cfg_num_out;
                ch_cnt  <= '0;
                out_cnt <= '0;
            end else if (out_hs) begin
                ch_cnt  <= '0;
                out_cnt <= out_cnt + ONE;
            end else if (beat_acc) begin
                ch_cnt <= ch_cnt + ONE;
            end
        end
    end

    // Gating on state lets out_data drop to zero the moment reset asserts,
    // even though the accumulator register itself clears on the next edge.
    assign out_data = (state == OUT) ? acc_sum : '0;
    assign done     = done_q;

endmodule

// File: tb/tb_accum_channel_sched.sv
// Directed self-checking bench for accum_channel_sched (DW=16, CW=8).
module tb_accum_channel_sched;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  cfg_num_ch;
    logic [7:0]  cfg_num_out;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_ready;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_ready;
    logic        busy;
    logic        done;

    int vectors;
    int miscompares;

    accum_channel_sched #(
        .DW(16),
        .CW(8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .cfg_num_ch  (cfg_num_ch),
        .cfg_num_out (cfg_num_out),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_ready   (out_ready),
        .busy        (busy),
        .done        (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic applyStimulus(input logic s, input logic [7:0] nch, input logic [7:0] nout,
                                 input logic iv, input logic [15:0] d, input logic ordy);
        start       = s;
        cfg_num_ch  = nch;
        cfg_num_out = nout;
        in_valid    = iv;
        in_data     = d;
        out_ready   = ordy;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        checkOutput({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        checkOutput({tag, "_out_data"}, 32'(out_data), 32'd0);
    endtask

    task automatic checkSum(input string tag, input logic [15:0] expected);
        checkOutput({tag, "_out_valid"}, 32'(out_valid), 32'd1);
        checkOutput({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        checkOutput({tag, "_out_data"}, 32'(out_data), 32'(expected));
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        applyStimulus(1'b0, 8'd0, 8'd0, 1'b0, 16'd0, 1'b0);
        step();
        step();
        checkIdle("reset");
        checkOutput("reset_done", 32'(done), 32'd0);
        rst = 1'b0;
        step();
        checkIdle("post_reset");

        $display("[TB] single output job");
        applyStimulus(1'b1, 8'd3, 8'd1, 1'b0, 16'd0, 1'b0);
        step();
        checkOutput("single_busy", 32'(busy), 32'd1);
        checkOutput("single_in_ready", 32'(in_ready), 32'd1);
        applyStimulus(1'b0, 8'd0, 8'd0, 1'b1, 16'd5, 1'b0);
        step();
        in_data = 16'd7;
        step();
        checkOutput("single_no_early_valid", 32'(out_valid), 32'd0);
        in_data = 16'd9;
        step();
        checkSum("single_sum", 16'd21);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        checkOutput("single_done", 32'(done), 32'd1);
        checkOutput("single_busy_drop", 32'(busy), 32'd0);
        out_ready = 1'b0;
        step();
        checkOutput("single_done_once", 32'(done), 32'd0);

        $display("[TB] back-to-back multi output job");
        applyStimulus(1'b1, 8'd2, 8'd3, 1'b0, 16'd0, 1'b1);
        step();
        applyStimulus(1'b0, 8'd0, 8'd0, 1'b1, 16'd1, 1'b1);
        step();
        in_data = 16'd2;
        step();
        checkSum("b2b_sum0", 16'd3);
        in_data = 16'd3;
        step();
        checkOutput("b2b_hs0_no_done", 32'(done), 32'd0);
        checkOutput("b2b_hs0_in_ready", 32'(in_ready), 32'd1);
        step();
        in_data = 16'd4;
        step();
        checkSum("b2b_sum1", 16'd7);
        in_data = 16'd5;
        step();
        checkOutput("b2b_hs1_no_done", 32'(done), 32'd0);
        step();
        in_data = 16'd6;
        step();
        checkSum("b2b_sum2", 16'd11);
        in_valid = 1'b0;
        step();
        checkOutput("b2b_done", 32'(done), 32'd1);
        checkOutput("b2b_busy_drop", 32'(busy), 32'd0);
        step();
        checkOutput("b2b_done_once", 32'(done), 32'd0);

        $display("[TB] backpressure and gaps");
        applyStimulus(1'b1, 8'd2, 8'd2, 1'b0, 16'd0, 1'b0);
        step();
        applyStimulus(1'b0, 8'd0, 8'd0, 1'b1, 16'd10, 1'b0);
        step();
        in_valid = 1'b0;
        step();
        step();
        checkOutput("gap_in_ready", 32'(in_ready), 32'd1);
        checkOutput("gap_out_valid", 32'(out_valid), 32'd0);
        in_valid = 1'b1;
        in_data  = 16'd20;
        step();
        checkSum("bp_sum0", 16'd30);
        in_data = 16'd99;
        for (int i = 0; i < 4; i++) begin
            step();
            checkSum("bp_hold0", 16'd30);
        end
        out_ready = 1'b1;
        in_data   = 16'd1;
        step();
        out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        step();
        in_valid = 1'b1;
        in_data  = 16'd2;
        step();
        checkSum("bp_sum1", 16'd3);
        in_data = 16'd77;
        step();
        checkSum("bp_hold1", 16'd3);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        checkOutput("bp_done", 32'(done), 32'd1);
        out_ready = 1'b0;

        $display("[TB] wrap and zero configuration");
        applyStimulus(1'b1, 8'd2, 8'd1, 1'b0, 16'd0, 1'b0);
        step();
        applyStimulus(1'b0, 8'd0, 8'd0, 1'b1, 16'hFFFF, 1'b0);
        step();
        in_data = 16'h0002;
        step();
        checkSum("wrap_sum", 16'h0001);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        checkOutput("wrap_done", 32'(done), 32'd1);
        applyStimulus(1'b1, 8'd0, 8'd0, 1'b0, 16'd0, 1'b0);
        step();
        applyStimulus(1'b0, 8'd0, 8'd0, 1'b1, 16'd42, 1'b0);
        step();
        checkSum("zero_cfg_sum", 16'd42);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        checkOutput("zero_cfg_done", 32'(done), 32'd1);
        applyStimulus(1'b1, 8'd0, 8'd2, 1'b0, 16'd0, 1'b0);
        step();
        applyStimulus(1'b0, 8'd0, 8'd0, 1'b1, 16'd5, 1'b0);
        step();
        checkSum("zero_ch_sum0", 16'd5);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        checkOutput("zero_ch_mid_done", 32'(done), 32'd0);
        applyStimulus(1'b0, 8'd0, 8'd0, 1'b1, 16'd6, 1'b0);
        step();
        checkSum("zero_ch_sum1", 16'd6);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        checkOutput("zero_ch_done", 32'(done), 32'd1);

        $display("[TB] reset mid job");
        applyStimulus(1'b1, 8'd3, 8'd1, 1'b0, 16'd0, 1'b0);
        step();
        applyStimulus(1'b0, 8'd0, 8'd0, 1'b1, 16'd8, 1'b0);
        step();
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checkIdle("async_reset");
        checkOutput("async_reset_done", 32'(done), 32'd0);
        step();
        rst = 1'b0;
        applyStimulus(1'b1, 8'd3, 8'd1, 1'b0, 16'd0, 1'b0);
        step();
        applyStimulus(1'b0, 8'd0, 8'd0, 1'b1, 16'd4, 1'b0);
        step();
        step();
        step();
        checkSum("after_reset_sum", 16'd12);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        checkOutput("after_reset_done", 32'(done), 32'd1);

        $display("[TB] start while busy");
        applyStimulus(1'b1, 8'd2, 8'd1, 1'b0, 16'd0, 1'b0);
        step();
        applyStimulus(1'b1, 8'd5, 8'd3, 1'b1, 16'd3, 1'b0);
        step();
        applyStimulus(1'b0, 8'd0, 8'd0, 1'b1, 16'd4, 1'b0);
        step();
        checkSum("busy_start_sum", 16'd7);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        checkOutput("busy_start_done", 32'(done), 32'd1);
        checkOutput("busy_start_idle", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
